magnitude_window_accum: RTL and testbench
=========================================

// Module: magnitude_window_accum
// PURPOSE
//  Streaming, parametrised successor to the single-sample magnitude converter.
//  - Takes signed two's-complement samples over a valid/ready stream.
//  - Converts each sample to an unsigned magnitude, with optional saturation.
//  - Over each window of WINDOW samples, accumulates the magnitude sum and tracks the peak.
//  - Presents {sum, peak} on a registered valid/ready output. Sits between the sample front end and the detection logic.
// PARAMETERS
//  WIDTH     16  magnitude width; input sample is WIDTH+1 bits signed
//  WINDOW    4   samples per window, >= 2
//  SATURATE  1   1: magnitude of -2^WIDTH clamps to 2^WIDTH-1; 0: wraps to 0
//  SW        WIDTH+$clog2(WINDOW)  sum width (localparam)
// PORTS
//  clk       in   1        system clock
//  rst       in   1        synchronous reset, active-high
//  clear     in   1        abort current window, sync
//  in_valid  in   1        sample valid
//  in_ready  out  1        sample accepted when in_valid & in_ready
//  in_data   in   WIDTH+1  signed sample, MSB = sign
//  out_valid out  1        result valid, held until accepted
//  out_ready in   1        downstream accepts when out_valid & out_ready
//  out_sum   out  SW       sum of magnitudes over the window
//  out_peak  out  WIDTH    largest magnitude in the window
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is synchronous and active-high.
//  - Reset state: count=0, acc=0, peak=0, out_valid=0, out_sum=0, out_peak=0.
//  - Magnitude per sample (combinational):
//    - sign=0: in_data[WIDTH-1:0].
//    - sign=1: (~in_data[WIDTH-1:0])+1, truncated to WIDTH bits.
//    - in_data == {1'b1,{WIDTH{1'b0}}}: magnitude is {WIDTH{1'b1}} if SATURATE, else 0.
//  - in_ready = ~clear & ~(out_valid & ~out_ready). Combinational, no other dependencies.
//  - Accepting a sample with count < WINDOW-1:
//    - acc += mag, peak = max(peak, mag), count++.
//  - Accepting the sample with count == WINDOW-1:
//    - Next cycle: out_sum = acc+mag, out_peak = max(peak, mag), out_valid = 1.
//    - count, acc and peak return to 0 in the same cycle.
//    - Latency: result valid 1 cycle after the last sample is accepted.
//  - Output handshake:
//    - Accept with no new result: out_valid falls next cycle. out_sum/out_peak hold their last values.
//    - Accept and window completion in the same cycle: the new result loads and out_valid stays 1.
//  - Back-pressure: while out_valid & ~out_ready, in_ready = 0 and no sample is taken. acc, count and peak are frozen.
//  - clear: zeros count/acc/peak next cycle and drops any in_data that cycle. out_valid/out_sum/out_peak are untouched.
//  - rst has priority over clear. clear has priority over sample acceptance.
//  - Sum never overflows: SW bits hold WINDOW*(2^WIDTH-1).
//  - Count is a mod-WINDOW counter. WINDOW need not be a power of 2.
// TESTING (WIDTH=16, WINDOW=4 unless noted)
//  - Basic window:
//    - Stimulus: samples 17'h1FFFF, 17'h00005, 17'h1FFFB, 17'h00003, out_ready=1.
//    - Required: one cycle after the 4th accept, out_valid=1, out_sum=14, out_peak=5. out_valid falls the cycle after.
//  - Most-negative sample:
//    - Stimulus: 17'h10000 then 3x 17'h0.
//    - Required: out_peak=16'hFFFF and out_sum=65535 with SATURATE=1. out_peak=0 and out_sum=0 with SATURATE=0.
//  - Back-pressure:
//    - Stimulus: hold out_ready=0 after the first result.
//    - Required: in_ready=0 and result stable for 10 cycles. Raise out_ready: in_ready=1 the same cycle, and the next window accumulates correctly.
//  - Simultaneous events:
//    - Stimulus: out_ready=1 while the 4th sample of the next window is accepted.
//    - Required: out_valid stays 1 and the new sum/peak appear the next cycle.
//  - clear mid-window:
//    - Stimulus: 2 samples of mag 7, pulse clear with in_valid=1, then 4 samples of mag 1.
//    - Required: in_ready=0 during clear. Result is sum=4, peak=1.
//  - rst mid-window and with out_valid=1:
//    - Required: all outputs 0 next cycle. The following 4 samples form a fresh window.

Source files
------------

// File: rtl/magnitude_window_accum.sv
// Purpose: converts signed samples to magnitudes and reports {sum, peak} once per WINDOW samples.
// Latency: result registered and valid 1 cycle after the last sample of a window is accepted.
// Backpressure: in_ready drops while a result is held unaccepted; clear also blocks input for its cycle.
module magnitude_window_accum #(
    parameter int WIDTH    = 16,
    parameter int WINDOW   = 4,
    parameter bit SATURATE = 1'b1,
    localparam int SW      = WIDTH + $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_sum,
    output logic [WIDTH-1:0] out_peak
);

    localparam int            CW   = $clog2(WINDOW);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    logic [CW-1:0]    count;
    logic [SW-1:0]    acc;
    logic [WIDTH-1:0] peak;

    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] peak_next;
    logic [SW-1:0]    sum_next;
    logic             accept;
    logic             last;

    // Magnitude of the incoming sample; the most-negative code has no positive twin
    always_comb begin
        mag = in_data[WIDTH-1:0];
        if (in_data[WIDTH]) begin
            if (in_data[WIDTH-1:0] == '0) begin
                mag = SATURATE ? {WIDTH{1'b1}} : '0;
            end else begin
                mag = ~in_data[WIDTH-1:0] + 1'b1;
            end
        end
    end

    // Input is blocked during clear and while a result waits for downstream
    always_comb begin
        in_ready  = ~clear & ~(out_valid & ~out_ready);
        accept    = in_valid & in_ready;
        last      = (count == LAST);
        peak_next = (mag > peak) ? mag : peak;
        sum_next  = acc + {{(SW - WIDTH){1'b0}}, mag};
    end

    // Window state: clear and completion both restart the window
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            acc   <= '0;
            peak  <= '0;
        end else if (clear) begin
            count <= '0;
            acc   <= '0;
            peak  <= '0;
        end else if (accept) begin
            if (last) begin
                count <= '0;
                acc   <= '0;
                peak  <= '0;
            end else begin
                count <= count + 1'b1;
                acc   <= sum_next;
                peak  <= peak_next;
            end
        end
    end

    // Output register: a completing window wins over the drain of the previous result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_peak  <= '0;
        end else if (accept && last) begin
            out_valid <= 1'b1;
            out_sum   <= sum_next;
            out_peak  <= peak_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_magnitude_window_accum.sv
// Purpose: self-checking bench for magnitude_window_accum (saturating and wrapping instances).
// Latency: results are checked through a scoreboard when the output handshake completes.
// Backpressure: out_ready is held low for several cycles to exercise stall and release.
module tb_magnitude_window_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [16:0] in_data;
    logic        out_ready;

    logic        in_ready,  out_valid;
    logic [17:0] out_sum;
    logic [15:0] out_peak;
    logic        in_ready0, out_valid0;
    logic [17:0] out_sum0;
    logic [15:0] out_peak0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [17:0] sum;
        logic [15:0] peak;
    } res_t;

    typedef struct {
        logic [16:0] d [4];
        logic [17:0] s1;
        logic [15:0] p1;
        logic [17:0] s0;
        logic [15:0] p0;
    } vec_t;

    res_t q1[$];
    res_t q0[$];
    res_t e1, e0;
    vec_t tbl [5];

    magnitude_window_accum #(.WIDTH(16), .WINDOW(4), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_peak(out_peak)
    );

    magnitude_window_accum #(.WIDTH(16), .WINDOW(4), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_sum(out_sum0), .out_peak(out_peak0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [16:0] a, input logic [16:0] b,
                           input logic [16:0] c, input logic [16:0] d,
                           input logic [17:0] s1, input logic [15:0] p1,
                           input logic [17:0] s0, input logic [15:0] p0);
        tbl[idx].d[0] = a;
        tbl[idx].d[1] = b;
        tbl[idx].d[2] = c;
        tbl[idx].d[3] = d;
        tbl[idx].s1   = s1;
        tbl[idx].p1   = p1;
        tbl[idx].s0   = s0;
        tbl[idx].p0   = p0;
    endtask

    task automatic push_exp(input logic [17:0] s1, input logic [15:0] p1,
                            input logic [17:0] s0, input logic [15:0] p0);
        q1.push_back('{sum: s1, peak: p1});
        q0.push_back('{sum: s0, peak: p0});
    endtask

    // Offer one sample and return just after the edge that accepts it
    task automatic send(input logic [16:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_win(input int idx, input bit push);
        for (int i = 0; i < 4; i++) send(tbl[idx].d[i]);
        if (push) push_exp(tbl[idx].s1, tbl[idx].p1, tbl[idx].s0, tbl[idx].p0);
    endtask

    // Scoreboard: compare every result that completes the output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sat_unexpected_out: got sum %0d peak 0x%0h, expected no result", out_sum, out_peak);
            end else begin
                e1 = q1.pop_front();
                chk("sat_out_sum", 32'(out_sum), 32'(e1.sum));
                chk("sat_out_peak", 32'(out_peak), 32'(e1.peak));
            end
        end
        if (!rst && out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wrap_unexpected_out: got sum %0d peak 0x%0h, expected no result", out_sum0, out_peak0);
            end else begin
                e0 = q0.pop_front();
                chk("wrap_out_sum", 32'(out_sum0), 32'(e0.sum));
                chk("wrap_out_peak", 32'(out_peak0), 32'(e0.peak));
            end
        end
    end

    initial begin
        // sample order left to right; magnitudes worked out by hand
        set_vec(0, 17'h1FFFF, 17'h00005, 17'h1FFFB, 17'h00003, 18'd14, 16'd5, 18'd14, 16'd5);
        set_vec(1, 17'h10000, 17'h00000, 17'h00000, 17'h00000, 18'd65535, 16'hFFFF, 18'd0, 16'd0);
        set_vec(2, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 18'd262140, 16'hFFFF, 18'd262140, 16'hFFFF);
        set_vec(3, 17'h10001, 17'h00002, 17'h18000, 17'h00000, 18'd98305, 16'hFFFF, 18'd98305, 16'hFFFF);
        set_vec(4, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 18'd0, 16'd0, 18'd0, 16'd0);

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_sum", 32'(out_sum), 32'd0);
        chk("reset_out_peak", 32'(out_peak), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Table windows: latency and single-cycle valid pulse for each
        for (int v = 0; v < 5; v++) begin
            send_win(v, 1'b1);
            chk("latency_valid", 32'(out_valid), 32'd1);
            chk("latency_valid_wrap", 32'(out_valid0), 32'd1);
            @(posedge clk);
            #1;
            chk("valid_fall", 32'(out_valid), 32'd0);
        end

        // Back-to-back windows: each result drains while the next window streams in
        send_win(0, 1'b1);
        send_win(3, 1'b1);
        send_win(2, 1'b1);
        chk("stream_last_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("stream_valid_fall", 32'(out_valid), 32'd0);

        // Back-pressure: result held 10 cycles, input stalled, clear leaves the result alone
        out_ready = 1'b0;
        send_win(0, 1'b1);
        in_valid = 1'b1;
        in_data  = tbl[3].d[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_sum", 32'(out_sum), 32'd14);
            chk("bp_out_peak", 32'(out_peak), 32'd5);
        end
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_keeps_valid", 32'(out_valid), 32'd1);
        chk("clear_keeps_sum", 32'(out_sum), 32'd14);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        send_win(3, 1'b1);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_sum", 32'(out_sum), 32'd98305);
        @(posedge clk);
        #1;

        // clear mid-window drops the partial sum and the sample offered during clear
        send(17'h1FFF9);
        send(17'h00007);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 17'h00009;
        #1;
        chk("clear_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        send(17'h00001);
        send(17'h1FFFF);
        send(17'h00001);
        send(17'h1FFFF);
        push_exp(18'd4, 16'd1, 18'd4, 16'd1);
        chk("clear_result_sum", 32'(out_sum), 32'd4);
        chk("clear_result_peak", 32'(out_peak), 32'd1);
        @(posedge clk);
        #1;

        // rst mid-window: the next 4 samples form a fresh window
        send(17'h0FFFF);
        send(17'h0FFFF);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_out_sum", 32'(out_sum), 32'd0);
        send_win(0, 1'b1);
        chk("rst_mid_fresh_sum", 32'(out_sum), 32'd14);
        @(posedge clk);
        #1;

        // rst while a result is held: outputs clear and the result is discarded
        out_ready = 1'b0;
        send_win(2, 1'b0);
        chk("rst_hold_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_out_sum", 32'(out_sum), 32'd0);
        chk("rst_hold_out_peak", 32'(out_peak), 32'd0);
        chk("rst_hold_wrap_valid", 32'(out_valid0), 32'd0);
        out_ready = 1'b1;
        send_win(3, 1'b1);
        @(posedge clk);
        #1;

        // Drain the scoreboard with a bounded wait
        for (int c = 0; c < 20 && (q1.size() != 0 || q0.size() != 0); c++) @(posedge clk);
        chk("sat_queue_empty", 32'(q1.size()), 32'd0);
        chk("wrap_queue_empty", 32'(q0.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
